// File: rtl/fadd_normalize_if.sv
// Handshake and data bundle between the align/add stage, the post-addition
// normalizer and the rounding stage.
//
// Upstream side (align/add -> normalizer):
//   in_valid  sum valid
//   in_ready  normalizer can accept
//   s_in      result sign
//   e_in      biased exponent before normalization
//   sum_in    29-bit significand sum ([28] carry-out, [27] hidden bit, [3:0] guard/sticky)
// Downstream side (normalizer -> rounder):
//   out_valid result valid
//   out_ready rounder accepts
//   s_out     sign
//   e_out     normalized biased exponent
//   m_out     28-bit normalized significand (hidden bit [27], guard [3], sticky [2:0])
//   zero      sum was exactly zero
//   ovf       exponent overflowed to 255
//
// The slave modport is the normalizer; the master modport is whatever drives
// the sum in and consumes the result (the surrounding datapath or a bench).
interface fadd_normalize_if;
    logic        in_valid;
    logic        in_ready;
    logic        s_in;
    logic [7:0]  e_in;
    logic [28:0] sum_in;
    logic        out_valid;
    logic        out_ready;
    logic        s_out;
    logic [7:0]  e_out;
    logic [27:0] m_out;
    logic        zero;
    logic        ovf;

    modport slave (
        input  in_valid, s_in, e_in, sum_in, out_ready,
        output in_ready, out_valid, s_out, e_out, m_out, zero, ovf
    );

    modport master (
        output in_valid, s_in, e_in, sum_in, out_ready,
        input  in_ready, out_valid, s_out, e_out, m_out, zero, ovf
    );
endinterface

// File: rtl/fadd_normalize.sv
// Multi-cycle post-addition normalizer for the binary32 adder/subtractor.
// Takes the raw significand sum and pre-shift exponent, resolves carry-out,
// cancellation (left shifts of up to 4 bits per cycle), the denormal floor and
// exponent overflow, and presents a 28-bit normalized significand to the rounder.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  synchronous active-low reset
//   bus    fadd_normalize_if.slave: in_valid/in_ready + s_in/e_in/sum_in in,
//          out_valid/out_ready + s_out/e_out/m_out/zero/ovf out
//
// One operation is in flight at a time: IDLE accepts, SHIFT normalizes,
// DONE holds the result until the rounder takes it.
module fadd_normalize (
    input  logic            clk,
    input  logic            rst_n,
    fadd_normalize_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        s_reg, s_next;
    logic [7:0]  e_reg, e_next;
    logic [27:0] m_reg, m_next;
    logic        zero_reg, zero_next;
    logic        ovf_reg, ovf_next;

    logic        accept;
    logic [7:0]  e_carry;
    logic [2:0]  lz;
    logic [7:0]  e_minus1;
    logic [2:0]  k;
    logic [27:0] m_shifted;
    logic [27:0] shift_cand [0:4];

    assign accept  = bus.in_valid && bus.in_ready;
    assign e_carry = bus.e_in + 8'd1;

    // Leading zeros of the top nibble; 4 means the whole nibble is clear and
    // another full 4-bit step may be possible.
    always_comb begin
        lz = 3'd4;
        if (m_reg[27])      lz = 3'd0;
        else if (m_reg[26]) lz = 3'd1;
        else if (m_reg[25]) lz = 3'd2;
        else if (m_reg[24]) lz = 3'd3;
    end

    // Shift is limited so the exponent never goes below 1 while in SHIFT;
    // e_reg >= 1 is guaranteed there, so e_reg - 1 never wraps.
    assign e_minus1 = e_reg - 8'd1;
    assign k        = (e_minus1 < {5'd0, lz}) ? e_minus1[2:0] : lz;

    // Candidate left shifts of 0..4; k selects one.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_shift
            assign shift_cand[gi] = m_reg << gi;
        end
    endgenerate

    assign m_shifted = shift_cand[k];

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        e_next     = e_reg;
        m_next     = m_reg;
        zero_next  = zero_reg;
        ovf_next   = ovf_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    s_next     = bus.s_in;
                    zero_next  = 1'b0;
                    ovf_next   = 1'b0;
                    state_next = DONE;
                    if (bus.sum_in == 29'd0) begin
                        m_next    = 28'd0;
                        e_next    = 8'd0;
                        zero_next = 1'b1;
                    end else if (bus.sum_in[28]) begin
                        // Carry-out: shift right one, folding the two lowest
                        // bits into the sticky position.
                        if (e_carry == 8'hFF) begin
                            ovf_next = 1'b1;
                            m_next   = 28'd0;
                            e_next   = 8'hFF;
                        end else begin
                            m_next = {bus.sum_in[28:2], bus.sum_in[1] | bus.sum_in[0]};
                            e_next = e_carry;
                        end
                    end else if (bus.sum_in[27]) begin
                        m_next = bus.sum_in[27:0];
                        e_next = bus.e_in;
                    end else if (bus.e_in <= 8'd1) begin
                        // Already at the denormal floor; no shift allowed.
                        m_next = bus.sum_in[27:0];
                        e_next = 8'd0;
                    end else begin
                        m_next     = bus.sum_in[27:0];
                        e_next     = bus.e_in;
                        state_next = SHIFT;
                    end
                end
            end

            SHIFT: begin
                m_next = m_shifted;
                e_next = e_reg - {5'd0, k};
                if (!(lz == 3'd4 && k == 3'd4)) begin
                    state_next = DONE;
                    // Hidden bit not reached: floor hit, encode as denormal.
                    if (!m_shifted[27]) begin
                        e_next = 8'd0;
                    end
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            s_reg     <= 1'b0;
            e_reg     <= 8'd0;
            m_reg     <= 28'd0;
            zero_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            e_reg     <= e_next;
            m_reg     <= m_next;
            zero_reg  <= zero_next;
            ovf_reg   <= ovf_next;
        end
    end

    // in_ready is gated by rst_n so nothing is offered while reset is held.
    assign bus.in_ready  = (state_reg == IDLE) && rst_n;
    assign bus.out_valid = (state_reg == DONE);
    assign bus.s_out     = s_reg;
    assign bus.e_out     = e_reg;
    assign bus.m_out     = m_reg;
    assign bus.zero      = zero_reg;
    assign bus.ovf       = ovf_reg;

endmodule

// File: doc/fadd_normalize.md
# fadd_normalize

Multi-cycle post-addition normalizer for the single-precision FPU adder/subtractor. It accepts the raw 29-bit significand sum and the pre-shift exponent from the align/add stage. It handles carry-out, massive cancellation, the denormal floor and exponent overflow. It delivers a 28-bit normalized significand (hidden bit at [27], guard at [3], sticky bits [2:0]) with its sign and exponent directly to the rounding stage over a valid/ready handshake.

## Interface
- No parameters; widths fixed for binary32.
- CLK  in  1  clock; all state changes on rising edge
- RST_N  in  1  reset, synchronous, active-low
- IN_VALID  in  1  upstream sum valid
- IN_READY  out  1  block can accept; equals (state==IDLE) and RST_N high
- S_IN  in  1  result sign
- E_IN  in  8  biased exponent before normalization
- SUM_IN  in  29  significand sum; [28] carry-out, [27] hidden-bit position, [3:0] guard/sticky
- OUT_VALID  out  1  result valid (state==DONE)
- OUT_READY  in  1  rounding stage accepts
- S_OUT  out  1  sign; connects to rounder S_G
- E_OUT  out  8  normalized biased exponent
- M_OUT  out  28  normalized significand; connects to rounder M_IN
- ZERO  out  1  sum was exactly zero
- OVF  out  1  exponent overflowed to 255

## Operation
- FSM states: IDLE, SHIFT, DONE. Internal registers S_R, E_R[7:0], M_R[27:0], ZERO, OVF. Outputs are driven from these registers.
- IDLE, on IN_VALID&IN_READY: latch S_IN, clear ZERO/OVF, classify SUM_IN in priority order:
  - SUM_IN==0: M_R=0, E_R=0, ZERO=1 -> DONE.
  - SUM_IN[28]=1: M_R={SUM_IN[28:2], SUM_IN[1]|SUM_IN[0]}, E_R=E_IN+1. If E_IN+1==255: OVF=1, M_R=0, E_R=255. Then -> DONE.
  - SUM_IN[27]=1: M_R=SUM_IN[27:0], E_R=E_IN -> DONE.
  - E_IN<=1: M_R=SUM_IN[27:0], E_R=0 -> DONE. Already at the denormal floor.
  - otherwise: M_R=SUM_IN[27:0], E_R=E_IN -> SHIFT.
- SHIFT, once per cycle:
  - lz = leading zeros of M_R[27:24] (0..4; 4 if nibble is zero).
  - k = min(lz, E_R-1).
  - M_R <<= k, zero-filled; E_R -= k.
  - If lz==4 and k==4: stay in SHIFT.
  - Otherwise -> DONE. On this transition, if the shifted M_R[27]==0 (floor hit), E_R is written as 0 (denormal encoding).
- SHIFT never drops set bits; all shifts are left, so sticky content is preserved.
- DONE: OUT_VALID=1, all outputs held stable. On OUT_READY -> IDLE.
- No accept in the same cycle as OUT_VALID&OUT_READY. IN_READY rises the cycle after the handshake.

## Timing
- Reset (RST_N low at an edge), regardless of state:
  - state=IDLE
  - OUT_VALID=0, S_OUT=0, E_OUT=0, M_OUT=0, ZERO=0, OVF=0
  - IN_READY=0 while RST_N is low
- Reset mid-SHIFT or mid-DONE discards the operation. No output is produced for it.
- Acceptance at edge T, fast path (zero, carry, already normalized, floor): OUT_VALID high from T+1.
- Slow path, with L = leading zeros of SUM_IN[27:0] above the floor: OUT_VALID high from T+2+floor(L/4). Worst case is L=27 -> T+8.
- Floor-limited path ends at the first SHIFT cycle where k<lz.
- Backpressure: OUT_VALID and all data stay constant while OUT_READY=0, for any number of cycles.
- Throughput: one operation per (latency+1) cycles minimum. No pipelining across operations.
- Exponent arithmetic is 8-bit unsigned. E_R-1 is evaluated only when E_R>=1, which SHIFT guarantees.

## Test plan
- Already normalized: SUM_IN=29'h0800_0000, E_IN=8'h7F, OUT_READY=1 -> OUT_VALID at T+1, M_OUT=28'h800_0000, E_OUT=8'h7F, ZERO=OVF=0.
- Carry-out with sticky fold: SUM_IN=29'h1000_0003, E_IN=8'h80 -> T+1, M_OUT=28'h800_0001, E_OUT=8'h81.
- Massive cancellation: SUM_IN=29'h0000_0010, E_IN=8'h40 -> OUT_VALID at T+7, M_OUT=28'h800_0000, E_OUT=8'h29.
- Denormal floor: SUM_IN=29'h0000_1000, E_IN=8'h05 -> OUT_VALID at T+3, M_OUT=28'h001_0000, E_OUT=8'h00.
- Overflow: SUM_IN=29'h1000_0000, E_IN=8'hFE -> T+1, OVF=1, E_OUT=8'hFF, M_OUT=0.
- Zero, backpressure and reset:
  - SUM_IN=0, E_IN=8'h55 -> ZERO=1, E_OUT=0, M_OUT=0.
  - Hold OUT_READY=0 for 5 cycles -> outputs stable, IN_READY=0 throughout.
  - Pull RST_N low in DONE -> OUT_VALID=0 and all outputs 0 after that edge; IN_READY=1 on the first cycle after RST_N returns high.
